// File: rtl/note_tone_player_pkg.sv
// Shared note constants, pitch tables, request struct and FSM states for the note tone player.
package note_pkg;

  localparam int w_note    = 12;
  localparam int w_ms      = 16;
  localparam int w_dur_max = 16;

  localparam logic [w_note-1:0] C  = 12'b1000_0000_0000;
  localparam logic [w_note-1:0] Cs = 12'b0100_0000_0000;
  localparam logic [w_note-1:0] D  = 12'b0010_0000_0000;
  localparam logic [w_note-1:0] Ds = 12'b0001_0000_0000;
  localparam logic [w_note-1:0] E  = 12'b0000_1000_0000;
  localparam logic [w_note-1:0] F  = 12'b0000_0100_0000;
  localparam logic [w_note-1:0] Fs = 12'b0000_0010_0000;
  localparam logic [w_note-1:0] G  = 12'b0000_0001_0000;
  localparam logic [w_note-1:0] Gs = 12'b0000_0000_1000;
  localparam logic [w_note-1:0] A  = 12'b0000_0000_0100;
  localparam logic [w_note-1:0] As = 12'b0000_0000_0010;
  localparam logic [w_note-1:0] B  = 12'b0000_0000_0001;

  localparam logic [w_note-1:0] Df = Cs;
  localparam logic [w_note-1:0] Ef = Ds;
  localparam logic [w_note-1:0] Gf = Fs;
  localparam logic [w_note-1:0] Af = Gs;
  localparam logic [w_note-1:0] Bf = As;

  // Indexed by one-hot bit position, so C4 sits at index 11 and B4 at index 0.
  localparam int unsigned freq_100 [w_note-1:0] = '{
    26163, 27718, 29366, 31113, 32963, 34923,
    36999, 39200, 41530, 44000, 46616, 49388
  };

  function automatic logic [17:0] half_period(input int clk_mhz, input int idx);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'(clk_mhz) * 64'd100_000_000;
    den = 64'(freq_100[idx]) * 64'd2;
    return 18'(num / den);
  endfunction

  typedef struct packed {
    logic [w_note-1:0]    note;
    logic [1:0]           octave;
    logic [w_dur_max-1:0] dur_ms;
  } note_req_t;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

endpackage

// File: rtl/note_tone_player_if.sv
// Request channel between a melody sequencer (master) and the note tone player (slave).
interface note_tone_player_if #(
  parameter int w_dur = 12
);
  import note_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [w_note-1:0] req_note;
  logic [1:0]        req_octave;
  logic [w_dur-1:0]  req_dur_ms;

  modport master (output req_valid, req_note, req_octave, req_dur_ms, input req_ready);
  modport slave  (input req_valid, req_note, req_octave, req_dur_ms, output req_ready);

endinterface

// File: rtl/note_tone_player_ms_ticker.sv
// Millisecond prescaler: pulses tick once every clk_mhz*1000 cycles, restartable via clr.
module ms_ticker #(
  parameter int clk_mhz = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int period = clk_mhz * 1000;
  localparam int w_cnt  = (period > 1) ? $clog2(period) : 1;

  logic [w_cnt-1:0] cnt;

  assign tick = (cnt == w_cnt'(period - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + w_cnt'(1);
    end
  end

endmodule

// File: rtl/note_tone_player.sv
// Square-wave tone player: plays one requested note, then a fixed silent gap, then accepts the next.
// Define NOTE_TONE_PLAYER_DECAY_EN to halve the tone amplitude every 64 ms of playing.
module note_tone_player
  import note_pkg::*;
#(
  parameter int                 clk_mhz   = 50,
  parameter logic signed [15:0] amplitude = 16'sh2000,
  parameter int                 gap_ms    = 10,
  parameter int                 w_dur     = 12
) (
  input  logic               clk,
  input  logic               rst,
  note_tone_player_if.slave  req,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] sound
);

  state_t             state, next_state;
  note_req_t          req_q;
  logic               accept, tick, clr, play_end, gap_end, tone_en;
  logic [w_ms-1:0]    ms_cnt, ms_step;
  logic [17:0]        half_tab [w_note];
  logic [17:0]        half, phase_cnt, phase_cnt_n;
  logic               phase, phase_n;
  logic [3:0]         idx;
  logic [1:0]         oct_eff;
  logic signed [15:0] amp_n, sound_n;

  for (genvar i = 0; i < w_note; i++) begin : g_half
    localparam logic [17:0] hp = half_period(clk_mhz, i);
    assign half_tab[i] = hp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (stop) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (req.req_valid) next_state = PLAY;
        PLAY:    if (play_end)      next_state = GAP;
        GAP:     if (gap_end)       next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    req.req_ready = (state == IDLE) && !stop;
    accept        = (state == IDLE) && !stop && req.req_valid;
    busy          = (state != IDLE);
    done          = (state == GAP) && gap_end && !stop;
  end

  // Timers restart on every state change so each phase is measured from its own first cycle.
  assign clr      = stop || (state == IDLE) || (next_state != state);
  assign ms_step  = ms_cnt + w_ms'(tick);
  assign play_end = (ms_step == w_ms'(req_q.dur_ms));
  assign gap_end  = (ms_step == w_ms'(gap_ms));

  ms_ticker #(.clk_mhz(clk_mhz)) u_ticker (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    idx = '0;
    for (int i = 0; i < w_note; i++) begin
      if (req_q.note[i]) idx = 4'(i);
    end
  end

  assign tone_en = $onehot(req_q.note);
  assign oct_eff = (req_q.octave == 2'd3) ? 2'd2 : req_q.octave;
  assign half    = half_tab[idx] >> oct_eff;

`ifdef NOTE_TONE_PLAYER_DECAY_EN
  logic signed [15:0] amp_live;

  always_comb begin
    amp_n = amp_live;
    if (accept) amp_n = amplitude;
    else if (state == PLAY && tick && ms_cnt[5:0] == 6'd63) amp_n = amp_live >>> 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) amp_live <= '0;
    else      amp_live <= amp_n;
  end
`else
  assign amp_n = amplitude;
`endif

  // Sound is registered, so it is computed from next-cycle phase to hit +amplitude on the first PLAY cycle.
  always_comb begin
    sound_n     = '0;
    phase_cnt_n = '0;
    phase_n     = 1'b0;
    if (accept) begin
      if ($onehot(req.req_note) && (req.req_dur_ms != '0)) sound_n = amp_n;
    end else if (state == PLAY && next_state == PLAY) begin
      if (phase_cnt + 18'd1 >= half) begin
        phase_cnt_n = '0;
        phase_n     = ~phase;
      end else begin
        phase_cnt_n = phase_cnt + 18'd1;
        phase_n     = phase;
      end
      if (tone_en) sound_n = phase_n ? -amp_n : amp_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q     <= '0;
      ms_cnt    <= '0;
      phase_cnt <= '0;
      phase     <= 1'b0;
      sound     <= '0;
    end else begin
      if (accept) begin
        req_q.note   <= req.req_note;
        req_q.octave <= req.req_octave;
        req_q.dur_ms <= w_dur_max'(req.req_dur_ms[w_dur-1:0]);
      end
      if (clr)       ms_cnt <= '0;
      else if (tick) ms_cnt <= ms_cnt + w_ms'(1);
      phase_cnt <= phase_cnt_n;
      phase     <= phase_n;
      sound     <= sound_n;
    end
  end

endmodule
